// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC generation, IMEM read issue and a small {pc, inst}
// FIFO feeding ID, with ID stall back-pressure and EX redirect flushing.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             imem_en,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_dout,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic [CNT_W-1:0] fetch_count
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic BOOT = 1'b0;
    localparam logic RUN  = 1'b1;

    logic             state;
    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic [31:0]      addr_q;
    logic             inflight;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_inst [DEPTH];

    logic             has_fifo;
    logic             bypass;
    logic             head_exists;
    logic             pop;
    logic             rd_adv;
    logic             push;
    logic             issue;
    logic [CW:0]      occ;
    logic [31:0]      target;
    logic [31:0]      issue_addr;
    logic [31:0]      head_pc;
    logic [31:0]      head_inst;
    logic             unused_lo;

    assign unused_lo   = ^redirect_pc[1:0];
    assign target      = {redirect_pc[31:2], 2'b00};

    // An empty FIFO forwards the response arriving this cycle straight to ID.
    assign has_fifo    = count != '0;
    assign bypass      = !has_fifo && inflight && !redirect;
    assign head_exists = has_fifo || bypass;
    assign head_pc     = has_fifo ? fifo_pc[rd_ptr] : inflight_pc;
    assign head_inst   = has_fifo ? fifo_inst[rd_ptr] : imem_dout;

    assign id_valid    = head_exists && !redirect && !rst;
    assign id_inst     = id_valid ? head_inst : NOP;
    assign id_pc       = rst ? RESET_PC
                       : (head_exists ? head_pc : fetch_pc);

    assign pop         = id_valid && !stall;
    assign rd_adv      = pop && !bypass;
    assign push        = inflight && !redirect && !(bypass && pop);

    // Count the in-flight read so a full FIFO can always absorb it.
    assign occ         = (CW+1)'(count) + (CW+1)'(inflight)
                       - (CW+1)'(pop);
    assign issue       = (state == RUN) && !rst
                       && (redirect || occ < (CW+1)'(DEPTH));
    assign issue_addr  = redirect ? target : fetch_pc;

    assign imem_en     = issue;
    assign imem_addr   = issue ? issue_addr : addr_q;
    assign fetch_count = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            addr_q      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            cnt_q       <= '0;
        end else begin
            state    <= RUN;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= issue_addr;
                fetch_pc    <= issue_addr + 32'd4;
                addr_q      <= issue_addr;
            end else if (redirect) begin
                fetch_pc    <= target;
            end
            if (pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(rd_adv);
            end
            assert (!(push && !rd_adv && count == CW'(DEPTH)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_inst[wr_ptr] <= imem_dout;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: IMEM model, directed and random stall/redirect/rst
// stimulus, and a PC-stream scoreboard checked by a negedge monitor.
module tb_if_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout = '0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] fetch_count;

    int          errs = 0;
    int          checks = 0;
    bit          started = 1'b0;
    int          since = 0;
    int          srun = 0;
    logic [31:0] cnt_m = '0;
    logic [31:0] exp_q [$];

    if_fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (2),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_dout <= mem_word(imem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Expected stream: queue head is the next PC ID must see.
    always @(negedge clk) begin
        logic [31:0] p;
        if (rst) begin
            started = 1'b1;
            chk("rst_valid", 32'(id_valid), 32'd0);
            chk("rst_en", 32'(imem_en), 32'd0);
            chk("rst_inst", id_inst, NOP);
            chk("rst_pc", id_pc, RESET_PC);
            cnt_m = '0;
            since = 0;
            srun  = 0;
        end else if (started) begin
            chk("fetch_count", fetch_count, cnt_m);
            if (!id_valid) chk("nop_inst", id_inst, NOP);
            if (since == 0) begin
                chk("boot_en", 32'(imem_en), 32'd0);
                chk("boot_valid", 32'(id_valid), 32'd0);
            end else if (redirect || since == 1) begin
                chk("issue_valid", 32'(id_valid), 32'd0);
                chk("issue_en", 32'(imem_en), 32'd1);
                chk("issue_addr", imem_addr, exp_q[0]);
            end else begin
                chk("valid", 32'(id_valid), 32'd1);
                chk("id_pc", id_pc, exp_q[0]);
                chk("id_inst", id_inst, mem_word(exp_q[0]));
            end
            if (since >= 2 && !redirect && stall) srun++;
            else srun = 0;
            if (srun >= 2) chk("stall_full_en", 32'(imem_en), 32'd0);
            if (id_valid && !stall) begin
                p = exp_q.pop_front();
                if (exp_q.size() == 0) exp_q.push_back(p + 32'd4);
                cnt_m = cnt_m + 32'd1;
            end
            if (since < 2) since++;
        end
    end

    task automatic drive(input logic r, input logic s, input logic rd,
                         input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        if (r) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
        end else if (rd) begin
            exp_q.delete();
            exp_q.push_back({rpc[31:2], 2'b00});
        end
    endtask

    initial begin
        logic        s;
        logic        rd;
        logic [31:0] t;
        exp_q.push_back(RESET_PC);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8) drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h4000_0100);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h4000_0102);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h4000_0200);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 5) begin
                repeat ($urandom_range(1, 3))
                    drive(1'b1, 1'b0, 1'b0, 32'h0);
            end else begin
                s  = ($urandom_range(0, 2) == 0);
                rd = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 3) == 0) t = $urandom();
                else t = RESET_PC + ($urandom() & 32'h0000_FFFF);
                drive(1'b0, s, rd, t);
            end
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
